bus_reg_bank: RTL and testbench

//   Bus-side receiver for the shared 8-bit tri-state data bus: captures bus values into a small register bank.

---
 rtl/bus_reg_bank_if.sv | 32 +++
 rtl/bus_reg_bank.sv | 82 ++++++++
 tb/tb_bus_reg_bank.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_reg_bank_if.sv
// Control and observation bundle for bus_reg_bank.
// The slave modport is the register bank's view of the bundle.
// The master modport is the controller's view, as seen from the sequencer or a bench.
// The shared tri-state data bus is not part of this bundle.
// It stays a plain inout port so that every driver of that net is visible at each level.
interface bus_reg_bank_if #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int AW    = 2
);
    logic             load_en;
    logic [AW-1:0]    load_sel;
    logic             out_en;
    logic [AW-1:0]    out_sel;
    logic [AW-1:0]    a_sel;
    logic [AW-1:0]    b_sel;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [NREGS-1:0] valid;
    logic             conflict;
    logic [7:0]       load_cnt;

    modport slave (
        input  load_en, load_sel, out_en, out_sel, a_sel, b_sel,
        output reg_a, reg_b, valid, conflict, load_cnt
    );

    modport master (
        output load_en, load_sel, out_en, out_sel, a_sel, b_sel,
        input  reg_a, reg_b, valid, conflict, load_cnt
    );
endinterface

// File: rtl/bus_reg_bank.sv
// bus_reg_bank: bus-side receiver that captures the shared tri-state data bus into a small register bank.
// - Presents two selected registers to the ALU as operands reg_a and reg_b.
// - Can drive one register back onto the bus.
// Optional feature: define REG_BYPASS_EN to forward the bus value combinationally to reg_a/reg_b
//   when the operand select matches the register being loaded in the same cycle.
module bus_reg_bank #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    inout  wire  [WIDTH-1:0] bus,
    bus_reg_bank_if.slave    ctrl
);

    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] valid_q;
    logic             conflict_q;
    logic [7:0]       load_cnt_q;

    logic [AW-1:0]    ld_sel;
    logic [AW-1:0]    drv_sel;
    logic [AW-1:0]    rd_a_sel;
    logic [AW-1:0]    rd_b_sel;
    logic [WIDTH-1:0] a_val;
    logic [WIDTH-1:0] b_val;

    assign ld_sel   = ctrl.load_sel;
    assign drv_sel  = ctrl.out_sel;
    assign rd_a_sel = ctrl.a_sel;
    assign rd_b_sel = ctrl.b_sel;

    // The bus is released as soon as reset asserts, independent of out_en, so a
    // block held in reset never fights the ALU or another bus master.
    assign bus = (rst_n && ctrl.out_en) ? regs[drv_sel] : {WIDTH{1'bz}};

    // Register bank, valid bits, load counter and conflict flag all update on one edge.
    // A load while this block drives the bus is a plain copy of whatever the bus carries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            valid_q    <= '0;
            conflict_q <= 1'b0;
            load_cnt_q <= '0;
        end else begin
            if (ctrl.load_en) begin
                regs[ld_sel]    <= bus;
                valid_q[ld_sel] <= 1'b1;
                if (load_cnt_q != 8'hFF) begin
                    load_cnt_q <= load_cnt_q + 8'd1;
                end
            end
            conflict_q <= ctrl.load_en & ctrl.out_en;
        end
    end

    // Operand read mux; the optional forward is suppressed while driving the bus,
    // since forwarding our own drive would close a combinational loop through the bus.
    always_comb begin
        a_val = regs[rd_a_sel];
        b_val = regs[rd_b_sel];
`ifdef REG_BYPASS_EN
        if (ctrl.load_en && !ctrl.out_en && (rd_a_sel == ld_sel)) begin
            a_val = bus;
        end
        if (ctrl.load_en && !ctrl.out_en && (rd_b_sel == ld_sel)) begin
            b_val = bus;
        end
`else
`endif
    end

    assign ctrl.reg_a    = a_val;
    assign ctrl.reg_b    = b_val;
    assign ctrl.valid    = valid_q;
    assign ctrl.conflict = conflict_q;
    assign ctrl.load_cnt = load_cnt_q;

endmodule

// File: tb/tb_bus_reg_bank.sv
// Bench for bus_reg_bank.
// - Runs directed scenarios, then randomized traffic.
// - Every result is compared against a register-array reference model kept in this bench.
// - Release of the bus is observed by driving a probe pattern from the bench
//   and reading it back unchanged.
module tb_bus_reg_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tb_data;
    logic       tb_oe;
    wire  [7:0] bus;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_regs [4];
    logic [3:0] m_valid;
    int         m_cnt;
    logic       m_conflict;

    always #5 clk = ~clk;

    assign bus = tb_oe ? tb_data : 8'bz;

    bus_reg_bank_if #(.WIDTH(8), .NREGS(4), .AW(2)) ctrl ();

    bus_reg_bank #(.WIDTH(8), .NREGS(4), .AW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .ctrl  (ctrl)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_valid    = 4'b0000;
        m_cnt      = 0;
        m_conflict = 1'b0;
    endtask

    // Expected operand: stored value, or the bench's bus value when forwarding applies.
    function automatic logic [7:0] exp_operand(input logic [1:0] sel);
        logic [7:0] v;
        v = m_regs[sel];
`ifdef REG_BYPASS_EN
        if (rst_n && ctrl.load_en && !ctrl.out_en && tb_oe && sel == ctrl.load_sel) v = tb_data;
`endif
        return v;
    endfunction

    task automatic check_output(input string tag);
        check({tag, ".reg_a"},    32'(ctrl.reg_a),    32'(exp_operand(ctrl.a_sel)));
        check({tag, ".reg_b"},    32'(ctrl.reg_b),    32'(exp_operand(ctrl.b_sel)));
        check({tag, ".valid"},    32'(ctrl.valid),    32'(m_valid));
        check({tag, ".conflict"}, 32'(ctrl.conflict), 32'(m_conflict));
        check({tag, ".load_cnt"}, 32'(ctrl.load_cnt), 32'(m_cnt));
    endtask

    // One clock edge with the currently applied inputs; the model advances at the edge.
    task automatic apply_stimulus();
        logic [7:0] bus_val;
        bus_val = tb_oe ? tb_data : (ctrl.out_en ? m_regs[ctrl.out_sel] : 8'h00);
        @(posedge clk);
        if (ctrl.load_en) begin
            m_regs[ctrl.load_sel]  = bus_val;
            m_valid[ctrl.load_sel] = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
        m_conflict = ctrl.load_en && ctrl.out_en;
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        tb_oe         = 1'b0;
        tb_data       = 8'h00;
        ctrl.load_en  = 1'b0;
        ctrl.load_sel = 2'd0;
        ctrl.out_en   = 1'b0;
        ctrl.out_sel  = 2'd0;
        ctrl.a_sel    = 2'd0;
        ctrl.b_sel    = 2'd1;
        model_reset();

        // Reset state
        #12;
        check_output("reset");
        check("reset.reg_a_const", 32'(ctrl.reg_a), 32'h0);
        check("reset.load_cnt_const", 32'(ctrl.load_cnt), 32'h0);
        tb_oe   = 1'b1;
        tb_data = 8'h5A;
        #1;
        check("reset.bus_released", 32'(bus), 32'h5A);
        tb_oe = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Directed load of 8'h3C into register 2
        tb_oe         = 1'b1;
        tb_data       = 8'h3C;
        ctrl.load_en  = 1'b1;
        ctrl.load_sel = 2'd2;
        apply_stimulus();
        ctrl.load_en = 1'b0;
        tb_oe        = 1'b0;
        ctrl.a_sel   = 2'd2;
        #1;
        check("load3c.reg_a", 32'(ctrl.reg_a), 32'h3C);
        check("load3c.valid", 32'(ctrl.valid), 32'h4);
        check("load3c.cnt",   32'(ctrl.load_cnt), 32'h1);
        check_output("load3c");

        // Drive register 1 onto the bus, then release it
        tb_oe         = 1'b1;
        tb_data       = 8'hA5;
        ctrl.load_en  = 1'b1;
        ctrl.load_sel = 2'd1;
        apply_stimulus();
        ctrl.load_en = 1'b0;
        tb_oe        = 1'b0;
        ctrl.out_en  = 1'b1;
        ctrl.out_sel = 2'd1;
        #1;
        check("drive.bus_a5", 32'(bus), 32'hA5);
        ctrl.out_en = 1'b0;
        tb_oe       = 1'b1;
        tb_data     = 8'h00;
        #1;
        check("drive.bus_released", 32'(bus), 32'h00);
        tb_oe = 1'b0;

        // Simultaneous load and drive copies register 1 into register 3
        ctrl.out_en   = 1'b1;
        ctrl.out_sel  = 2'd1;
        ctrl.load_en  = 1'b1;
        ctrl.load_sel = 2'd3;
        ctrl.b_sel    = 2'd3;
        apply_stimulus();
        ctrl.out_en  = 1'b0;
        ctrl.load_en = 1'b0;
        #1;
        check("conflict.reg3", 32'(ctrl.reg_b), 32'hA5);
        check("conflict.flag", 32'(ctrl.conflict), 32'h1);
        check_output("conflict");
        apply_stimulus();
        check("conflict.cleared", 32'(ctrl.conflict), 32'h0);

        // Same-register conflict is a self-copy
        ctrl.out_en   = 1'b1;
        ctrl.out_sel  = 2'd2;
        ctrl.load_en  = 1'b1;
        ctrl.load_sel = 2'd2;
        apply_stimulus();
        ctrl.out_en  = 1'b0;
        ctrl.load_en = 1'b0;
        #1;
        check("selfcopy.reg2", 32'(ctrl.reg_a), 32'h3C);
        check_output("selfcopy");

        // Load 8'h77 into register 0: forwarded before the edge only with bypass
        tb_oe         = 1'b1;
        tb_data       = 8'h77;
        ctrl.load_en  = 1'b1;
        ctrl.load_sel = 2'd0;
        ctrl.a_sel    = 2'd0;
        #1;
`ifdef REG_BYPASS_EN
        check("bypass.pre_edge", 32'(ctrl.reg_a), 32'h77);
`else
        check("bypass.pre_edge", 32'(ctrl.reg_a), 32'h00);
`endif
        check_output("bypass_pre");
        apply_stimulus();
        ctrl.load_en = 1'b0;
        tb_oe        = 1'b0;
        #1;
        check("bypass.post_edge", 32'(ctrl.reg_a), 32'h77);

        // Randomized traffic against the model
        for (int n = 0; n < 200; n++) begin
            ctrl.out_en   = ($urandom_range(0, 3) == 0);
            ctrl.load_en  = $urandom_range(0, 1) == 1;
            ctrl.load_sel = 2'($urandom_range(0, 3));
            ctrl.out_sel  = 2'($urandom_range(0, 3));
            ctrl.a_sel    = 2'($urandom_range(0, 3));
            ctrl.b_sel    = 2'($urandom_range(0, 3));
            tb_data       = 8'($urandom);
            if (ctrl.out_en) tb_oe = 1'b0;
            else if (ctrl.load_en) tb_oe = 1'b1;
            else tb_oe = $urandom_range(0, 1) == 1;
            #1;
            if (ctrl.out_en) check("rand.bus_drive", 32'(bus), 32'(m_regs[ctrl.out_sel]));
            check_output("rand_pre");
            apply_stimulus();
            check_output("rand_post");
        end

        // Long run of loads saturates the counter
        ctrl.out_en  = 1'b0;
        ctrl.load_en = 1'b1;
        tb_oe        = 1'b1;
        for (int n = 0; n < 300; n++) begin
            ctrl.load_sel = 2'(n);
            tb_data       = 8'(n * 7);
            apply_stimulus();
        end
        ctrl.load_en = 1'b0;
        tb_oe        = 1'b0;
        #1;
        check("saturate.cnt", 32'(ctrl.load_cnt), 32'hFF);
        check_output("saturate");

        // Reset asserted between edges with a load pending
        ctrl.load_en  = 1'b1;
        ctrl.load_sel = 2'd1;
        tb_oe         = 1'b1;
        tb_data       = 8'hEE;
        ctrl.a_sel    = 2'd1;
        ctrl.b_sel    = 2'd2;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst.reg_a", 32'(ctrl.reg_a), 32'h0);
        check("async_rst.cnt",   32'(ctrl.load_cnt), 32'h0);
        check_output("async_rst");
        ctrl.out_en  = 1'b1;
        ctrl.out_sel = 2'd2;
        tb_data      = 8'h5A;
        #1;
        check("async_rst.bus_released", 32'(bus), 32'h5A);
        @(posedge clk);
        #1;
        check_output("rst_held");
        @(negedge clk);
        ctrl.load_en = 1'b0;
        ctrl.out_en  = 1'b0;
        tb_oe        = 1'b0;
        rst_n        = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ctrl.a_sel = 2'(i);
            #1;
            check("after_rst.reg", 32'(ctrl.reg_a), 32'h0);
        end
        apply_stimulus();
        check_output("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
